// File: rtl/ice40_bram_pkg.sv
// Shared constants for driving an SB_RAM40_4K in 256x16 mode.
package ice40_bram_pkg;

    localparam int BRAM_AW = 11;
    localparam int BRAM_DW = 16;
    localparam logic [1:0] RAM_MODE_256X16 = 2'd0;
    localparam logic [BRAM_DW-1:0] BRAM_MASK_ALL = '0;

    typedef logic [BRAM_AW-1:0] bram_addr_t;

    // Occupancy can reach depth + 2 (RAM plus the output buffer).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/ice40_bram_fifo_ctrl_if.sv
// Push/pop valid-ready handshake bundle for the BRAM FIFO controller.
interface ice40_bram_fifo_ctrl_if #(parameter int WIDTH = 16);

    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_ready;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );

endinterface

// File: rtl/ice40_fifo_out_buf.sv
// 2-entry in-order output queue absorbing the BRAM read latency; head is show-ahead.
module ice40_fifo_out_buf
    import ice40_bram_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head, tail;
    logic [1:0]       occ_q;
    logic             pop;

    assign pop   = valid & ready;
    assign valid = occ_q != 2'd0;
    assign data  = head;
    assign occ   = occ_q;

    // Upstream never writes into a full queue, so no overflow case exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ice40_bram_fifo_ctrl.sv
// Single-clock FIFO controller around one SB_RAM40_4K (256x16): address/enable
// generation, read-latency absorption, valid/ready push and pop at 1 word/cycle.
module ice40_bram_fifo_ctrl
    import ice40_bram_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = cnt_width(2**ADDR_WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    ice40_bram_fifo_ctrl_if.slave bus,
    output logic [CNT_WIDTH-1:0] count,
    output bram_addr_t           WADDR,
    output logic [BRAM_DW-1:0]   WDATA,
    output logic                 WE,
    output logic                 WCLKE,
    output logic [BRAM_DW-1:0]   MASK,
    output bram_addr_t           RADDR,
    output logic                 RE,
    output logic                 RCLKE,
    input  logic [BRAM_DW-1:0]   RDATA
);

    localparam logic [ADDR_WIDTH:0] RAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic                  rd_pend;
    logic [1:0]            occ;
    logic [2:0]            slots;
    logic                  we, re, pop;

    // push_ready looks only at registered ram_count, never at pop_ready.
    assign bus.push_ready = ram_count != RAM_FULL;
    assign we  = bus.push_valid & bus.push_ready;
    assign pop = bus.pop_valid & bus.pop_ready;

    // Buffer slots committed after this edge: survivors of the pop plus the in-flight word.
    assign slots = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_pend};
    assign re    = (ram_count != '0) && (slots < 3'd2);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_count <= '0;
            rd_pend   <= 1'b0;
        end else begin
            if (we) wptr <= wptr + 1'b1;
            if (re) rptr <= rptr + 1'b1;
            case ({we, re})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ;
            endcase
            rd_pend <= re;
        end
    end

    ice40_fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk      (CLK),
        .rst      (RESET),
        .in_valid (rd_pend),
        .in_data  (RDATA[WIDTH-1:0]),
        .valid    (bus.pop_valid),
        .data     (bus.pop_data),
        .ready    (bus.pop_ready),
        .occ      (occ)
    );

    assign count = CNT_WIDTH'(ram_count) + CNT_WIDTH'(rd_pend) + CNT_WIDTH'(occ);

    assign WADDR = {{(BRAM_AW-ADDR_WIDTH){1'b0}}, wptr};
    assign RADDR = {{(BRAM_AW-ADDR_WIDTH){1'b0}}, rptr};
    assign WDATA = BRAM_DW'(bus.push_data);
    assign WE    = we;
    assign RE    = re;
    assign WCLKE = 1'b1;
    assign RCLKE = 1'b1;
    assign MASK  = BRAM_MASK_ALL;

endmodule
